// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the fifo write arbiter: FSM state encoding,
// the write data type and the width of the optional per-requester grant counters.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  typedef logic [7:0] data_t;

  localparam int unsigned STATS_W = 16;

  // Round-robin successor of a requester index.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// above ptr, wrapping modulo N, as both one-hot and binary index.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [PW-1:0] winner_idx,
  output logic          valid
);

  always_comb begin
    int unsigned idx;
    idx        = 0;
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!valid && req[PW'(idx)]) begin
        valid      = 1'b1;
        winner_idx = PW'(idx);
        winner     = N'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a fifo, with optional burst locking.
// Define FIFO_WR_ARB_STATS_EN to add per-requester saturating grant counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ENTRIES   = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         in_req,
  input  logic [NUM_REQ-1:0]         in_req_last,
  input  data_t [NUM_REQ-1:0]        in_req_data,
  input  logic                       in_fifo_is_full,
  output logic [NUM_REQ-1:0]         out_gnt,
  output logic                       out_write_ctrl,
  output data_t                      out_write_data
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][STATS_W-1:0] out_gnt_cnt
`endif
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BW = 5;
  localparam logic [BW-1:0] LAST_CNT = BW'(MAX_BURST - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 16 || ENTRIES < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: parameter out of range");
  end

  state_t             state, state_n;
  logic [PW-1:0]      rr_ptr, rr_ptr_n;
  logic [PW-1:0]      owner, owner_n;
  logic [BW-1:0]      beat_cnt, beat_cnt_n;
  logic [NUM_REQ-1:0] win_oh;
  logic [PW-1:0]      win_idx;
  logic               win_valid;
  logic [NUM_REQ-1:0] gnt;
  data_t              wr_data;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_pick (
    .req        (in_req),
    .ptr        (rr_ptr),
    .winner     (win_oh),
    .winner_idx (win_idx),
    .valid      (win_valid)
  );

  // Grant is combinational so an idle arbiter forwards a beat with zero latency.
  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    owner_n    = owner;
    beat_cnt_n = beat_cnt;
    gnt        = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (win_valid && !in_fifo_is_full) begin
            gnt = win_oh;
            if (in_req_last[win_idx] || MAX_BURST == 1) begin
              rr_ptr_n = PW'(wrap_inc(32'(win_idx), NUM_REQ));
            end else begin
              state_n    = LOCK;
              owner_n    = win_idx;
              beat_cnt_n = BW'(1);
            end
          end
        end
        LOCK: begin
          if (!in_req[owner]) begin
            state_n  = IDLE;
            rr_ptr_n = PW'(wrap_inc(32'(owner), NUM_REQ));
          end else if (!in_fifo_is_full) begin
            gnt = NUM_REQ'(1) << owner;
            if (in_req_last[owner] || beat_cnt == LAST_CNT) begin
              state_n  = IDLE;
              rr_ptr_n = PW'(wrap_inc(32'(owner), NUM_REQ));
            end else begin
              beat_cnt_n = beat_cnt + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      owner    <= owner_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  // Grant is one-hot, so OR-ing the gated data lanes forms the mux.
  always_comb begin
    wr_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        wr_data = wr_data | in_req_data[i];
      end
    end
  end

  assign out_gnt        = gnt;
  assign out_write_ctrl = |gnt;
  assign out_write_data = wr_data;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ-1:0][STATS_W-1:0] gnt_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && gnt_cnt[i] != {STATS_W{1'b1}}) begin
          gnt_cnt[i] <= gnt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign out_gnt_cnt = gnt_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vectors with literal expectations plus
// a per-cycle comparison against a transaction-level arbitration model.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NR    = 4;
  localparam int MB    = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR-1:0]    last;
  data_t [NR-1:0]   rdata;
  logic             full_drv;
  logic             fifo_mode;
  logic             pop;
  logic             in_full;
  logic [NR-1:0]    gnt;
  logic             wctl;
  data_t            wdata;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NR-1:0][STATS_W-1:0] gnt_cnt;
  int               m_cnt [NR];
`endif

  int fifo_cnt  = 0;
  int fifo_next = 0;
  int total     = 0;
  int bad       = 0;

  int m_owner = -1;
  int m_beats = 0;
  int m_start = 0;

  assign in_full = fifo_mode ? (fifo_cnt >= DEPTH) : full_drv;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .ENTRIES   (DEPTH),
    .MAX_BURST (MB)
  ) dut (
`ifdef FIFO_WR_ARB_STATS_EN
    .out_gnt_cnt     (gnt_cnt),
`endif
    .clk             (clk),
    .rst             (rst),
    .in_req          (req),
    .in_req_last     (last),
    .in_req_data     (rdata),
    .in_fifo_is_full (in_full),
    .out_gnt         (gnt),
    .out_write_ctrl  (wctl),
    .out_write_data  (wdata)
  );

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: one owner (or none), beats already taken, and where the next search starts.
  always @(negedge clk) begin
    int w;
    int idx;
    int eg;
    int ed;
    eg = 0;
    ed = 0;
    w  = -1;
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < NR; i++) check($sformatf("gnt_cnt%0d", i), int'(gnt_cnt[i]), m_cnt[i]);
`endif
    if (rst) begin
      m_owner = -1;
      m_beats = 0;
      m_start = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_start + k) % NR;
        if (w < 0 && req[idx]) w = idx;
      end
      if (w >= 0 && !in_full) begin
        eg = 1 << w;
        ed = int'(rdata[w]);
        if (last[w] || MB == 1) m_start = (w + 1) % NR;
        else begin
          m_owner = w;
          m_beats = 1;
        end
      end
    end else if (!req[m_owner]) begin
      m_start = (m_owner + 1) % NR;
      m_owner = -1;
    end else if (!in_full) begin
      eg = 1 << m_owner;
      ed = int'(rdata[m_owner]);
      m_beats++;
      if (last[m_owner] || m_beats >= MB) begin
        m_start = (m_owner + 1) % NR;
        m_owner = -1;
      end
    end
    check("model_gnt", int'(gnt), eg);
    check("model_write_ctrl", int'(wctl), (eg != 0) ? 1 : 0);
    check("model_write_data", int'(wdata), ed);
    if (fifo_mode) begin
      fifo_next = fifo_cnt + (wctl ? 1 : 0) - ((pop && fifo_cnt > 0) ? 1 : 0);
      check("fifo_no_overflow", (fifo_next <= DEPTH) ? 1 : 0, 1);
    end else begin
      fifo_next = 0;
    end
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < NR; i++) begin
      if (rst) m_cnt[i] = 0;
      else if (eg[i] && m_cnt[i] < 65535) m_cnt[i]++;
    end
`endif
  end

  always @(posedge clk) fifo_cnt <= fifo_next;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string name, input logic [NR-1:0] exp_gnt, input data_t exp_data);
    #2;
    check({name, "_gnt"}, int'(gnt), int'(exp_gnt));
    check({name, "_data"}, int'(wdata), int'(exp_data));
    tick();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b1111;
    last = 4'b1111;
    cyc("reset", 4'b0000, 8'h00);
    rst  = 1'b0;
    req  = '0;
    last = '0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    last      = '0;
    rdata     = '0;
    full_drv  = 1'b0;
    fifo_mode = 1'b0;
    pop       = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
`endif
    tick();

    // All requesting single beats: plain rotation.
    do_reset();
    rdata[0] = 8'h10; rdata[1] = 8'h11; rdata[2] = 8'h12; rdata[3] = 8'h13;
    req = 4'b1111; last = 4'b1111;
    cyc("rot0", 4'b0001, 8'h10);
    cyc("rot1", 4'b0010, 8'h11);
    cyc("rot2", 4'b0100, 8'h12);
    cyc("rot3", 4'b1000, 8'h13);
    cyc("rot4", 4'b0001, 8'h10);

    // Requester 2 burst with last on beat 3 blocks requester 0.
    do_reset();
    rdata[2] = 8'h21; rdata[0] = 8'h01;
    req = 4'b0100; last = 4'b0000;
    cyc("b_beat1", 4'b0100, 8'h21);
    req = 4'b0101;
    cyc("b_beat2", 4'b0100, 8'h21);
    last = 4'b0100;
    cyc("b_beat3", 4'b0100, 8'h21);
    req = 4'b0001; last = 4'b0000;
    cyc("b_req0", 4'b0001, 8'h01);
    req = 4'b0000;
    cyc("b_abort", 4'b0000, 8'h00);

    // Requester 1 without last is cut at MAX_BURST beats, then waits its turn.
    do_reset();
    rdata[1] = 8'h5C; rdata[0] = 8'hAA; rdata[3] = 8'h33;
    req = 4'b0010; last = 4'b0000;
    for (int i = 0; i < MB; i++) cyc("c_burst", 4'b0010, 8'h5C);
    req = 4'b1011; last = 4'b1011;
    cyc("c_req3", 4'b1000, 8'h33);
    cyc("c_req0", 4'b0001, 8'hAA);
    cyc("c_req1", 4'b0010, 8'h5C);
    req = '0; last = '0;

    // Full stalls a locked burst without consuming beats.
    do_reset();
    rdata[3] = 8'h3C; rdata[0] = 8'h0F;
    req = 4'b1000; last = 4'b0000;
    cyc("d_beat1", 4'b1000, 8'h3C);
    cyc("d_beat2", 4'b1000, 8'h3C);
    full_drv = 1'b1;
    req = 4'b1001;
    for (int i = 0; i < 3; i++) cyc("d_full", 4'b0000, 8'h00);
    full_drv = 1'b0;
    rdata[3] = 8'hA5;
    cyc("d_beat3", 4'b1000, 8'hA5);
    cyc("d_beat4", 4'b1000, 8'hA5);
    cyc("d_next", 4'b0001, 8'h0F);
    req = '0;
    cyc("d_abort", 4'b0000, 8'h00);

    // Owner drops mid-burst, then reset mid-burst.
    do_reset();
    rdata[0] = 8'h77; rdata[1] = 8'h88;
    req = 4'b0001; last = 4'b0000;
    cyc("e_beat1", 4'b0001, 8'h77);
    req = 4'b0010;
    cyc("e_drop", 4'b0000, 8'h00);
    cyc("e_req1", 4'b0010, 8'h88);
    rst = 1'b1; req = 4'b1111;
    cyc("e_rst", 4'b0000, 8'h00);
    rst = 1'b0; last = 4'b1111;
    cyc("e_after", 4'b0001, 8'h77);

    // Downstream fifo of depth 4 with slow drain.
    do_reset();
    fifo_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      req   = 4'($urandom);
      last  = 4'($urandom);
      rdata = $urandom;
      pop   = ($urandom_range(0, 3) == 0);
      tick();
    end
    fifo_mode = 1'b0;
    pop = 1'b0;

    // Random full and occasional reset.
    for (int i = 0; i < 300; i++) begin
      req      = 4'($urandom);
      last     = 4'($urandom);
      rdata    = $urandom;
      full_drv = ($urandom_range(0, 2) == 0);
      rst      = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;
    full_drv = 1'b0;

`ifdef FIFO_WR_ARB_STATS_EN
    do_reset();
    rdata[2] = 8'h42;
    req = 4'b0100; last = 4'b0100;
    for (int i = 0; i < 10; i++) cyc("s_beat", 4'b0100, 8'h42);
    req = '0;
    #2;
    check("stats_req2", int'(gnt_cnt[2]), 10);
    check("stats_req0", int'(gnt_cnt[0]), 0);
    check("stats_req1", int'(gnt_cnt[1]), 0);
    check("stats_req3", int'(gnt_cnt[3]), 0);
    tick();
`endif

    req = '0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
